// File: rtl/dbg_bus_master.sv
// rtl/dbg_bus_master.sv - UART-framed debug initiator for the native memory bus
// Receives 'W'/'R' frames, runs one bus transaction, and returns read data serially.
module dbg_bus_master #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int BUS_TIMEOUT   = 255,
  parameter int FRAME_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_uart_rxd,
  output logic        o_uart_txd,
  output logic        o_mem_valid,
  output logic        o_mem_instr,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic [31:0] i_mem_rdata,
  output logic        o_cpu_halt,
  output logic        o_err
);
  localparam int CW  = $clog2(CLKS_PER_BIT + 1);
  localparam int FTC = FRAME_TIMEOUT * CLKS_PER_BIT;
  localparam int FW  = $clog2(FTC + 1);
  localparam int BW  = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_TX} state_t;

  rx_state_t     r_rx_state, w_rx_state;
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic [CW-1:0] r_rx_clk, w_rx_clk;
  logic [2:0]    r_rx_bit, w_rx_bit;
  logic [7:0]    r_rx_shift, w_rx_shift;
  logic          r_rx_done, w_rx_done, r_rx_ferr, w_rx_ferr;

  state_t        r_state, w_state;
  logic [1:0]    r_idx, w_idx;
  logic          r_is_wr, w_is_wr;
  logic [31:0]   r_addr, w_addr, r_wdata, w_wdata, r_tx_word, w_tx_word;
  logic [3:0]    r_wstrb, w_wstrb;
  logic          r_valid, w_valid, r_halt, w_halt, r_err, w_err, r_txd, w_txd;
  logic [FW-1:0] r_frame_cnt, w_frame_cnt;
  logic [BW-1:0] r_bus_cnt, w_bus_cnt;
  logic [CW-1:0] r_tx_clk, w_tx_clk;
  logic [3:0]    r_tx_bit, w_tx_bit;
  logic [7:0]    w_tx_byte;

  // Receiver: start re-checked at half a bit, then one sample per bit period.
  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_clk   = r_rx_clk + 1'b1;
    w_rx_bit   = r_rx_bit;
    w_rx_shift = r_rx_shift;
    w_rx_done  = 1'b0;
    w_rx_ferr  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_clk = '0;
        if (r_rx_prev && !r_rx_s2) w_rx_state = RX_START;
      end
      RX_START: if (r_rx_clk == HALF_LAST) begin
        w_rx_clk   = '0;
        w_rx_bit   = '0;
        w_rx_state = r_rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rx_clk == BIT_LAST) begin
        w_rx_clk   = '0;
        w_rx_shift = {r_rx_s2, r_rx_shift[7:1]};
        w_rx_bit   = r_rx_bit + 3'd1;
        if (r_rx_bit == 3'd7) w_rx_state = RX_STOP;
      end
      RX_STOP: if (r_rx_clk == BIT_LAST) begin
        w_rx_clk   = '0;
        w_rx_state = RX_IDLE;
        w_rx_done  = r_rx_s2;
        w_rx_ferr  = !r_rx_s2;
      end
      default: w_rx_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_clk   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_done  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_s1    <= i_uart_rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state;
      r_rx_clk   <= w_rx_clk;
      r_rx_bit   <= w_rx_bit;
      r_rx_shift <= w_rx_shift;
      r_rx_done  <= w_rx_done;
      r_rx_ferr  <= w_rx_ferr;
    end
  end

  assign w_tx_byte = r_tx_word[{r_idx, 3'b000} +: 8];

  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_is_wr     = r_is_wr;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_tx_word   = r_tx_word;
    w_wstrb     = r_wstrb;
    w_valid     = r_valid;
    w_halt      = r_halt;
    w_err       = 1'b0;
    w_txd       = r_txd;
    w_frame_cnt = '0;
    w_bus_cnt   = '0;
    w_tx_clk    = '0;
    w_tx_bit    = r_tx_bit;
    case (r_state)
      S_IDLE: begin
        if (r_rx_ferr) begin
          w_err = 1'b1;
        end else if (r_rx_done) begin
          if (r_rx_shift == 8'h57 || r_rx_shift == 8'h52) begin
            w_state = S_ADDR;
            w_idx   = '0;
            w_is_wr = (r_rx_shift == 8'h57);
            w_halt  = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (r_rx_ferr || r_frame_cnt == FW'(FTC)) begin
          w_err   = 1'b1;
          w_halt  = 1'b0;
          w_state = S_IDLE;
        end else if (r_rx_done) begin
          // Shifting in from the top leaves the first byte in the low lane.
          w_idx = r_idx + 2'd1;
          if (r_state == S_ADDR) w_addr = {r_rx_shift, r_addr[31:8]};
          else w_wdata = {r_rx_shift, r_wdata[31:8]};
          if (r_idx == 2'd3) begin
            if (r_state == S_ADDR && r_is_wr) begin
              w_state = S_DATA;
            end else begin
              w_state = S_BUS;
              w_valid = 1'b1;
              w_wstrb = r_is_wr ? 4'hF : 4'h0;
            end
          end
        end else if (r_rx_state == RX_IDLE) begin
          w_frame_cnt = r_frame_cnt + 1'b1;
        end
      end
      S_BUS: begin
        if (i_mem_ready) begin
          w_valid = 1'b0;
          if (r_is_wr) begin
            w_state = S_IDLE;
            w_halt  = 1'b0;
          end else begin
            w_state   = S_TX;
            w_tx_word = i_mem_rdata;
            w_idx     = '0;
            w_tx_bit  = '0;
            w_txd     = 1'b0;
          end
        end else if (r_bus_cnt == BW'(BUS_TIMEOUT - 1)) begin
          w_valid = 1'b0;
          w_err   = 1'b1;
          w_halt  = 1'b0;
          w_state = S_IDLE;
        end else begin
          w_bus_cnt = r_bus_cnt + 1'b1;
        end
      end
      S_TX: begin
        if (r_tx_clk == BIT_LAST) begin
          if (r_tx_bit == 4'd9) begin
            if (r_idx == 2'd3) begin
              w_state = S_IDLE;
              w_halt  = 1'b0;
            end else begin
              w_idx    = r_idx + 2'd1;
              w_tx_bit = '0;
              w_txd    = 1'b0;
            end
          end else begin
            w_tx_bit = r_tx_bit + 4'd1;
            w_txd    = (r_tx_bit == 4'd8) ? 1'b1 : w_tx_byte[r_tx_bit[2:0]];
          end
        end else begin
          w_tx_clk = r_tx_clk + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_is_wr     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_tx_word   <= '0;
      r_wstrb     <= '0;
      r_valid     <= 1'b0;
      r_halt      <= 1'b0;
      r_err       <= 1'b0;
      r_txd       <= 1'b1;
      r_frame_cnt <= '0;
      r_bus_cnt   <= '0;
      r_tx_clk    <= '0;
      r_tx_bit    <= '0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_is_wr     <= w_is_wr;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_tx_word   <= w_tx_word;
      r_wstrb     <= w_wstrb;
      r_valid     <= w_valid;
      r_halt      <= w_halt;
      r_err       <= w_err;
      r_txd       <= w_txd;
      r_frame_cnt <= w_frame_cnt;
      r_bus_cnt   <= w_bus_cnt;
      r_tx_clk    <= w_tx_clk;
      r_tx_bit    <= w_tx_bit;
    end
  end

  assign o_uart_txd  = r_txd;
  assign o_mem_valid = r_valid;
  assign o_mem_instr = 1'b0;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_wstrb = r_wstrb;
  assign o_cpu_halt  = r_halt;
  assign o_err       = r_err;
endmodule
